// File: rtl/ntt_stage_sequencer.sv
// rtl/ntt_stage_sequencer.sv - in-place iterative NTT stage/butterfly sequencer
//
// Walks all LOG_N stages of an in-place NTT for one start pulse. Each butterfly
// takes five states:
//   RD_U  read U from the coefficient RAM
//   RD_V  read V and issue the twiddle address
//   EXEC  drive the arithmetic unit with the butterfly opcode
//   WR_U  write U' back to the RAM
//   WR_V  write V' back to the RAM
// Both results go back to the addresses they were read from.
//
// Optional feature: define NTT_SEQ_PERF_EN to add the perf_cycles busy-cycle counter.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start, q             start pulse; modulus, latched on the accepted start
//   busy, done           transform in progress; one-cycle completion pulse
//   mem_addr/mem_rd_en   coefficient RAM address and read strobe
//   mem_rdata            RAM read data (one-cycle read latency)
//   mem_wr_en/mem_wdata  RAM write strobe and write data
//   tw_addr/tw_rdata     twiddle ROM address and data (one-cycle read latency)
//   au_opcode, au_op_*   operands to the arithmetic unit
//   au_res_1/2           arithmetic unit results, valid one cycle after EXEC
//   perf_cycles          busy-cycle counter (NTT_SEQ_PERF_EN only)
module ntt_stage_sequencer #(
    parameter int LOG_N  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic [LOG_N-1:0]  mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [LOG_N-2:0]  tw_addr,
    input  logic [DATA_W-1:0] tw_rdata,
    output logic [2:0]        au_opcode,
    output logic [DATA_W-1:0] au_op_a,
    output logic [DATA_W-1:0] au_op_b,
    output logic [DATA_W-1:0] au_op_w,
    output logic [DATA_W-1:0] au_op_q,
    input  logic [DATA_W-1:0] au_res_1,
    input  logic [DATA_W-1:0] au_res_2
`ifdef NTT_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int S_W = (LOG_N > 1) ? $clog2(LOG_N) : 1;
    localparam logic [S_W-1:0]   S_LAST = S_W'(LOG_N - 1);
    localparam logic [LOG_N-2:0] K_LAST = '1;
    localparam logic [2:0]       OP_BUTTERFLY = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_U,
        S_RD_V,
        S_EXEC,
        S_WR_U,
        S_WR_V,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [S_W-1:0]      s_q, s_d;
    logic [LOG_N-2:0]    k_q, k_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [DATA_W-1:0]   u_q, u_d;
    logic [DATA_W-1:0]   vr_q, vr_d;

    // Butterfly index math. mask = half-1 = all-ones(LOG_N-1) >> s.
    // The low bits of k (below half) give j and the high bits give g, so
    // iu = 2*half*g + j is just the high bits shifted up by one with j below.
    logic [LOG_N-2:0] mask;
    logic [LOG_N-2:0] j_idx;
    logic [LOG_N-2:0] g_bits;
    logic [LOG_N-1:0] half;
    logic [LOG_N-1:0] iu;
    logic [LOG_N-1:0] iv;
    logic [LOG_N-2:0] tw_idx;

    always_comb begin
        mask   = {(LOG_N-1){1'b1}} >> s_q;
        j_idx  = k_q & mask;
        g_bits = k_q & ~mask;
        half   = {1'b0, mask} + LOG_N'(1);
        iu     = {g_bits, 1'b0} | {1'b0, j_idx};
        iv     = iu | half;
        tw_idx = j_idx << s_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            q_q     <= '0;
            u_q     <= '0;
            vr_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            q_q     <= q_d;
            u_q     <= u_d;
            vr_q    <= vr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        k_d       = k_q;
        q_d       = q_q;
        u_d       = u_q;
        vr_d      = vr_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        tw_addr   = '0;
        au_opcode = 3'b000;
        au_op_a   = '0;
        au_op_b   = '0;
        au_op_w   = '0;
        au_op_q   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_U;
                    q_d     = q;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            S_RD_U: begin
                busy      = 1'b1;
                mem_addr  = iu;
                mem_rd_en = 1'b1;
                state_d   = S_RD_V;
            end
            S_RD_V: begin
                busy      = 1'b1;
                mem_addr  = iv;
                mem_rd_en = 1'b1;
                tw_addr   = tw_idx;
                u_d       = mem_rdata;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                // V arrives this cycle and goes straight to the arithmetic
                // unit, which registers its operands itself.
                busy      = 1'b1;
                au_opcode = OP_BUTTERFLY;
                au_op_a   = u_q;
                au_op_b   = mem_rdata;
                au_op_w   = tw_rdata;
                au_op_q   = q_q;
                state_d   = S_WR_U;
            end
            S_WR_U: begin
                // The results are only valid in this cycle; V' is held for WR_V.
                busy      = 1'b1;
                mem_addr  = iu;
                mem_wr_en = 1'b1;
                mem_wdata = au_res_1;
                vr_d      = au_res_2;
                state_d   = S_WR_V;
            end
            S_WR_V: begin
                busy      = 1'b1;
                mem_addr  = iv;
                mem_wr_en = 1'b1;
                mem_wdata = vr_q;
                if (k_q != K_LAST) begin
                    k_d     = k_q + 1'b1;
                    state_d = S_RD_U;
                end else if (s_q != S_LAST) begin
                    k_d     = '0;
                    s_d     = s_q + 1'b1;
                    state_d = S_RD_U;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef NTT_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE && start) begin
            perf_d = '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb/tb_ntt_stage_sequencer.sv - directed bench for ntt_stage_sequencer
module tb_ntt_stage_sequencer;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // LOG_N = 4 instance
    logic          start4 = 1'b0;
    logic [DW-1:0] q4 = 64'd97;
    logic          busy4, done4, rd4, wr4;
    logic [3:0]    addr4;
    logic [DW-1:0] rdata4 = '0;
    logic [DW-1:0] wdata4;
    logic [2:0]    tw4;
    logic [DW-1:0] tw_rdata4 = '0;
    logic [2:0]    op4;
    logic [DW-1:0] a4, b4, w4, qo4;
    logic [DW-1:0] r1_4 = 64'hDEAD;
    logic [DW-1:0] r2_4 = 64'hBEEF;
    logic [DW-1:0] mem4 [16];

    // LOG_N = 2 instance
    logic          start2 = 1'b0;
    logic [DW-1:0] q2 = 64'd17;
    logic          busy2, done2, rd2, wr2;
    logic [1:0]    addr2;
    logic [DW-1:0] rdata2 = '0;
    logic [DW-1:0] wdata2;
    logic [0:0]    tw2;
    logic [DW-1:0] tw_rdata2 = '0;
    logic [2:0]    op2;
    logic [DW-1:0] a2, b2, w2, qo2;
    logic [DW-1:0] r1_2 = 64'hDEAD;
    logic [DW-1:0] r2_2 = 64'hBEEF;
    logic [DW-1:0] mem2 [4];

`ifdef NTT_SEQ_PERF_EN
    logic [31:0] perf4, perf2;
`endif

    ntt_stage_sequencer #(.LOG_N(4), .DATA_W(DW)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .q(q4),
        .busy(busy4), .done(done4),
        .mem_addr(addr4), .mem_rd_en(rd4), .mem_rdata(rdata4),
        .mem_wr_en(wr4), .mem_wdata(wdata4),
        .tw_addr(tw4), .tw_rdata(tw_rdata4),
        .au_opcode(op4), .au_op_a(a4), .au_op_b(b4), .au_op_w(w4), .au_op_q(qo4),
`ifdef NTT_SEQ_PERF_EN
        .perf_cycles(perf4),
`endif
        .au_res_1(r1_4), .au_res_2(r2_4)
    );

    ntt_stage_sequencer #(.LOG_N(2), .DATA_W(DW)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .q(q2),
        .busy(busy2), .done(done2),
        .mem_addr(addr2), .mem_rd_en(rd2), .mem_rdata(rdata2),
        .mem_wr_en(wr2), .mem_wdata(wdata2),
        .tw_addr(tw2), .tw_rdata(tw_rdata2),
        .au_opcode(op2), .au_op_a(a2), .au_op_b(b2), .au_op_w(w2), .au_op_q(qo2),
`ifdef NTT_SEQ_PERF_EN
        .perf_cycles(perf2),
`endif
        .au_res_1(r1_2), .au_res_2(r2_2)
    );

    // Cooley-Tukey butterfly: U' = U + W*V, V' = U - W*V (mod m)
    function automatic logic [63:0] bf_u(input logic [63:0] u, v, w, m);
        logic [127:0] t;
        t = (128'(w) * 128'(v)) % 128'(m);
        return 64'((128'(u) + t) % 128'(m));
    endfunction

    function automatic logic [63:0] bf_v(input logic [63:0] u, v, w, m);
        logic [127:0] t;
        t = (128'(w) * 128'(v)) % 128'(m);
        return 64'((128'(u) + 128'(m) - t) % 128'(m));
    endfunction

    // RAM, twiddle ROM and arithmetic unit models (one-cycle latency each)
    always @(posedge clk) begin
        if (rd4) rdata4 <= mem4[addr4];
        if (wr4) mem4[addr4] <= wdata4;
        tw_rdata4 <= 64'd3 + 64'(tw4);
        if (op4 == 3'b011) begin
            r1_4 <= bf_u(a4, b4, w4, qo4);
            r2_4 <= bf_v(a4, b4, w4, qo4);
        end else begin
            r1_4 <= 64'hDEAD;
            r2_4 <= 64'hBEEF;
        end
        if (rd2) rdata2 <= mem2[addr2];
        if (wr2) mem2[addr2] <= wdata2;
        tw_rdata2 <= 64'd1;
        if (op2 == 3'b011) begin
            r1_2 <= bf_u(a2, b2, w2, qo2);
            r2_2 <= bf_v(a2, b2, w2, qo2);
        end else begin
            r1_2 <= 64'hDEAD;
            r2_2 <= 64'hBEEF;
        end
    end

    // Address trace of the LOG_N=2 instance
    bit rec2 = 1'b0;
    bit prev_rd2 = 1'b0;
    int overlap = 0;
    int rd_tr[$];
    int wr_tr[$];
    int tw_tr[$];

    always @(negedge clk) begin
        if (rd4 && wr4) overlap++;
        if (rec2) begin
            if (rd2 && wr2) overlap++;
            if (rd2) rd_tr.push_back(int'(addr2));
            if (wr2) wr_tr.push_back(int'(addr2));
            if (rd2 && prev_rd2) tw_tr.push_back(int'(tw2));
            prev_rd2 = rd2;
        end else begin
            prev_rd2 = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle 0 is the cycle in which start is raised; cycle n is the one after
    // the n-th following rising edge. Optional extra start pulses at inj_a/inj_b.
    task automatic run_xform(input int which, input int inj_a, input int inj_b, input int limit,
                             output int done_cyc, output int n_done, output int busy_gaps);
        int cyc;
        bit d, b;
        done_cyc = -1;
        n_done = 0;
        busy_gaps = 0;
        cyc = 0;
        @(negedge clk);
        if (which == 2) start2 = 1'b1; else start4 = 1'b1;
        while (cyc < limit && !(done_cyc >= 0 && cyc >= done_cyc + 8)) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start2 = 1'b0;
            start4 = 1'b0;
            if (cyc == inj_a || cyc == inj_b) begin
                if (which == 2) start2 = 1'b1; else start4 = 1'b1;
            end
            if (which == 2) begin
                d = done2;
                b = busy2;
                if (cyc == 1) q2 = 64'd5;
            end else begin
                d = done4;
                b = busy4;
            end
            if (d) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                if (b) busy_gaps++;
            end else if (done_cyc < 0 && !b) begin
                busy_gaps++;
            end
        end
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc, nd, bg, cyc;
        logic [63:0] acc;
        int exp_ad[8];
        int exp_tw[4];
        logic [63:0] exp_ram2[4];
        exp_ad   = '{0, 2, 1, 3, 0, 1, 2, 3};
        exp_tw   = '{0, 1, 0, 0};
        exp_ram2 = '{64'd10, 64'd15, 64'd13, 64'd0};

        for (int i = 0; i < 16; i++) mem4[i] = '0;
        mem2[0] = 64'd1; mem2[1] = 64'd2; mem2[2] = 64'd3; mem2[3] = 64'd4;

        // Reset state
        repeat (2) @(negedge clk);
        chk_eq("rst_busy", 64'(busy4), 0);
        chk_eq("rst_done", 64'(done4), 0);
        chk_eq("rst_rd_wr", 64'({rd4, wr4}), 0);
        chk_eq("rst_addr_tw", 64'({addr4, tw4}), 0);
        chk_eq("rst_wdata", wdata4, 0);
        chk_eq("rst_opcode", 64'(op4), 0);
        chk_eq("rst_ops", a4 | b4 | w4 | qo4, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // LOG_N=2 functional run, q changed after acceptance
        rec2 = 1'b1;
        run_xform(2, 0, 0, 100, dc, nd, bg);
        rec2 = 1'b0;
        chk_eq("n2_done_cycle", 64'(dc), 21);
        chk_eq("n2_done_count", 64'(nd), 1);
        chk_eq("n2_busy_gaps", 64'(bg), 0);
        for (int i = 0; i < 4; i++) chk_eq($sformatf("n2_ram[%0d]", i), mem2[i], exp_ram2[i]);
        chk_eq("n2_rd_count", 64'(rd_tr.size()), 8);
        chk_eq("n2_wr_count", 64'(wr_tr.size()), 8);
        chk_eq("n2_tw_count", 64'(tw_tr.size()), 4);
        for (int i = 0; i < 8; i++) begin
            if (i < rd_tr.size()) chk_eq($sformatf("n2_rd_addr[%0d]", i), 64'(rd_tr[i]), 64'(exp_ad[i]));
            if (i < wr_tr.size()) chk_eq($sformatf("n2_wr_addr[%0d]", i), 64'(wr_tr[i]), 64'(exp_ad[i]));
        end
        for (int i = 0; i < 4; i++)
            if (i < tw_tr.size()) chk_eq($sformatf("n2_tw_addr[%0d]", i), 64'(tw_tr[i]), 64'(exp_tw[i]));

        // LOG_N=4, zero RAM, start pulses while busy and during DONE
        run_xform(4, 50, 161, 400, dc, nd, bg);
        chk_eq("n4_done_cycle", 64'(dc), 161);
        chk_eq("n4_done_count", 64'(nd), 1);
        chk_eq("n4_busy_gaps", 64'(bg), 0);
        chk_eq("n4_idle_after", 64'(busy4), 0);
        acc = '0;
        for (int i = 0; i < 16; i++) acc = acc | mem4[i];
        chk_eq("n4_ram_zero", acc, 0);
`ifdef NTT_SEQ_PERF_EN
        chk_eq("n4_perf", 64'(perf4), 160);
`endif

        // Next start after done is accepted normally
        run_xform(4, 0, 0, 400, dc, nd, bg);
        chk_eq("n4_restart_cycle", 64'(dc), 161);
        chk_eq("n4_restart_count", 64'(nd), 1);

        // Reset during WR_U of stage 1 (cycle 44)
        cyc = 0;
        @(negedge clk);
        start4 = 1'b1;
        while (cyc < 44) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start4 = 1'b0;
        end
        chk_eq("abort_pre_wr", 64'(wr4), 1);
        chk_eq("abort_pre_busy", 64'(busy4), 1);
        #2 rst = 1'b1;
        #1;
        chk_eq("abort_busy", 64'(busy4), 0);
        chk_eq("abort_rd_wr", 64'({rd4, wr4}), 0);
        chk_eq("abort_addr_wdata", 64'(addr4) | wdata4, 0);
        chk_eq("abort_opcode_done", 64'({op4, done4}), 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (180) begin
            @(negedge clk);
            if (done4) nd++;
        end
        chk_eq("abort_no_done", 64'(nd), 0);
        chk_eq("abort_idle_busy", 64'(busy4), 0);
        run_xform(4, 0, 0, 400, dc, nd, bg);
        chk_eq("post_abort_cycle", 64'(dc), 161);
        chk_eq("post_abort_count", 64'(nd), 1);
        chk_eq("post_abort_gaps", 64'(bg), 0);
`ifdef NTT_SEQ_PERF_EN
        chk_eq("post_abort_perf", 64'(perf4), 160);
`endif

        chk_eq("strobe_overlap", 64'(overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
